// File: rtl/fpu_pkg.sv
// Shared constants and types for the fpu result path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fpu_pkg;

   localparam int FPU_EXP_W = 7;
   localparam int FPU_MAN_W = 24;

   // One-hot status nibble
   localparam logic [3:0] ST_EXACT     = 4'b0001;
   localparam logic [3:0] ST_INEXACT   = 4'b0010;
   localparam logic [3:0] ST_OVERFLOW  = 4'b0100;
   localparam logic [3:0] ST_UNDERFLOW = 4'b1000;

   localparam logic [31:0] IEEE_INF  = 32'h7F80_0000;
   localparam logic [31:0] IEEE_QNAN = 32'h7FC0_0000;

   typedef enum logic [2:0] {
      CLS_ZERO,
      CLS_DENORM,
      CLS_NORMAL,
      CLS_SPECIAL,
      CLS_FLAGGED
   } cls_t;

endpackage

// File: rtl/fpu_to_ieee754_lzc24.sv
// Leading-one position encoder for a 24-bit fraction.
// Latency: combinational.
// Backpressure: none (pure logic).
//
// Ports:
//   i_d    : value to scan
//   o_p    : bit index of the most significant 1 (0 when i_d is zero)
//   o_zero : i_d is all zeros
module lzc24 (
   input  logic [23:0] i_d,
   output logic [4:0]  o_p,
   output logic        o_zero
);

   // Later (higher) set bits overwrite earlier ones, so the MSB wins.
   always_comb begin
      o_p = 5'd0;
      for (int i = 0; i < 24; i++) begin
         if (i_d[i]) o_p = 5'(i);
      end
   end

   assign o_zero = ~|i_d;

endmodule

// File: rtl/fpu_to_ieee754.sv
// Converts 1/7/24 fpu results (bias IN_BIAS) plus one-hot status into IEEE-754 binary32.
// Latency: 2 register stages (S1 classify, S2 pack/round); 1 result per cycle.
// Backpressure: valid/ready; in_ready = S1 free or draining, no comb path from in_valid.
//
// Build option: define FPU_STICKY_FLAGS_EN to include the sticky exception register;
// otherwise sticky_flags is tied to 000 and flags_clr is ignored.
//
// Ports:
//   clk, reset                : clock (rising edge), async active-low reset
//   in_valid/in_ready         : input handshake
//   in_data, in_status        : {sign, exp[6:0], frac[23:0]} and one-hot status
//   out_valid/out_ready       : output handshake
//   out_data, out_status      : binary32 word and merged one-hot status
//   flags_clr, sticky_flags   : clear and read {underflow, overflow, inexact} sticky bits
module fpu_to_ieee754
   import fpu_pkg::*;
#(
   parameter int IN_BIAS = 63
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic [3:0]  in_status,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [3:0]  out_status,
   input  logic        flags_clr,
   output logic [2:0]  sticky_flags
);

   // ---------------------------------------------------------------- flow control
   logic w_s2_adv;
   logic w_s1_adv;
   logic r_s1_vld;
   logic r_out_vld;

   assign w_s2_adv = ~r_out_vld | out_ready;
   assign w_s1_adv = ~r_s1_vld | w_s2_adv;
   assign in_ready = w_s1_adv;

   // ---------------------------------------------------------------- S1: classify
   logic                 w_in_sign;
   logic [FPU_EXP_W-1:0] w_in_exp;
   logic [FPU_MAN_W-1:0] w_in_frac;
   logic [4:0]           w_lzc_p;
   logic                 w_lzc_zero;
   cls_t                 w_cls;

   assign w_in_sign = in_data[31];
   assign w_in_exp  = in_data[30:24];
   assign w_in_frac = in_data[23:0];

   lzc24 u_lzc (
      .i_d    (w_in_frac),
      .o_p    (w_lzc_p),
      .o_zero (w_lzc_zero)
   );

   // Upstream flags take precedence over anything the data word says;
   // overflow is tested before underflow so it wins on a malformed nibble.
   always_comb begin
      w_cls = CLS_NORMAL;
      if (in_status[2] || in_status[3])   w_cls = CLS_FLAGGED;
      else if (w_in_exp == 7'h7F)         w_cls = CLS_SPECIAL;
      else if (w_in_exp == 7'h00)         w_cls = w_lzc_zero ? CLS_ZERO : CLS_DENORM;
   end

   logic                 r_s1_sign;
   logic [FPU_EXP_W-1:0] r_s1_exp;
   logic [FPU_MAN_W-1:0] r_s1_frac;
   logic [3:0]           r_s1_st;
   logic [4:0]           r_s1_p;
   cls_t                 r_s1_cls;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1_vld  <= 1'b0;
         r_s1_sign <= 1'b0;
         r_s1_exp  <= '0;
         r_s1_frac <= '0;
         r_s1_st   <= '0;
         r_s1_p    <= '0;
         r_s1_cls  <= CLS_ZERO;
      end else if (w_s1_adv) begin
         r_s1_vld <= in_valid;
         if (in_valid) begin
            r_s1_sign <= w_in_sign;
            r_s1_exp  <= w_in_exp;
            r_s1_frac <= w_in_frac;
            r_s1_st   <= in_status;
            r_s1_p    <= w_lzc_p;
            r_s1_cls  <= w_cls;
         end
      end
   end

   // ---------------------------------------------------------------- S2: pack/round
   // Denormal input: value = frac * 2^-86, leading one at p gives IEEE exponent p+41.
   logic [7:0]  w_den_exp;
   logic [22:0] w_den_frac;

   assign w_den_exp  = {3'b000, r_s1_p} + 8'd41;
   assign w_den_frac = 23'(r_s1_frac << (5'd23 - r_s1_p));

   // Normal input: drop frac[0] with round-to-nearest-even. Largest result
   // exponent is 126-63+127+1 = 191, so 8 bits suffice and inf is unreachable.
   logic [23:0] w_rnd;
   logic [7:0]  w_nrm_exp;

   assign w_rnd     = {1'b0, r_s1_frac[23:1]} + {23'b0, r_s1_frac[0] & r_s1_frac[1]};
   assign w_nrm_exp = {1'b0, r_s1_exp} + 8'(127 - IN_BIAS) + {7'b0, w_rnd[23]};

   logic [31:0] w_out_dat;
   logic [3:0]  w_out_st;

   always_comb begin
      w_out_dat = '0;
      w_out_st  = ST_EXACT;
      case (r_s1_cls)
         CLS_FLAGGED: begin
            if (r_s1_st[2]) begin
               w_out_dat = IEEE_INF;
               w_out_st  = ST_OVERFLOW;
            end else begin
               w_out_dat = 32'h0000_0000;
               w_out_st  = ST_UNDERFLOW;
            end
         end
         CLS_SPECIAL: begin
            w_out_dat = (r_s1_frac == '0) ? {r_s1_sign, 8'hFF, 23'b0} : IEEE_QNAN;
            w_out_st  = ST_OVERFLOW;
         end
         CLS_ZERO: begin
            w_out_dat = {r_s1_sign, 31'b0};
            w_out_st  = r_s1_st;
         end
         CLS_DENORM: begin
            w_out_dat = {r_s1_sign, w_den_exp, w_den_frac};
            w_out_st  = (r_s1_st == ST_INEXACT) ? ST_INEXACT : ST_EXACT;
         end
         default: begin
            // A rounding carry leaves w_rnd[22:0] all zero, which is the wanted fraction.
            w_out_dat = {r_s1_sign, w_nrm_exp, w_rnd[22:0]};
            w_out_st  = ((r_s1_st == ST_INEXACT) || r_s1_frac[0]) ? ST_INEXACT : ST_EXACT;
         end
      endcase
   end

   logic [31:0] r_out_dat;
   logic [3:0]  r_out_st;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out_vld <= 1'b0;
         r_out_dat <= '0;
         r_out_st  <= '0;
      end else if (w_s2_adv) begin
         r_out_vld <= r_s1_vld;
         if (r_s1_vld) begin
            r_out_dat <= w_out_dat;
            r_out_st  <= w_out_st;
         end
      end
   end

   assign out_valid  = r_out_vld;
   assign out_data   = r_out_dat;
   assign out_status = r_out_st;

   // ---------------------------------------------------------------- sticky flags
`ifdef FPU_STICKY_FLAGS_EN
   logic       w_out_hs;
   logic [2:0] r_sticky;

   assign w_out_hs = r_out_vld & out_ready;

   // Clear and set in the same cycle: the clear drops old bits, the new ones still land.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sticky <= 3'b000;
      end else if (flags_clr || w_out_hs) begin
         r_sticky <= (flags_clr ? 3'b000 : r_sticky) | (w_out_hs ? r_out_st[3:1] : 3'b000);
      end
   end

   assign sticky_flags = r_sticky;
`else
   logic w_unused_flags_clr;
   assign w_unused_flags_clr = flags_clr;
   assign sticky_flags       = 3'b000;
`endif

endmodule

// File: tb/tb_fpu_to_ieee754.sv
// Scoreboard bench for fpu_to_ieee754: directed vectors with hand-computed results.
// Driver pushes expected {status, data} on each accept; a negedge monitor pops on handshake.
// Also covers reset state, latency, backpressure/hold, sticky flags and mid-run reset.
module tb_fpu_to_ieee754;

`ifdef FPU_STICKY_FLAGS_EN
   localparam bit STK = 1'b1;
`else
   localparam bit STK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [3:0]  in_status;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_status;
   logic        flags_clr;
   logic [2:0]  sticky_flags;

   fpu_to_ieee754 #(.IN_BIAS(63)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_status    (in_status),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_status   (out_status),
      .flags_clr    (flags_clr),
      .sticky_flags (sticky_flags)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_acc   = 0;
   logic [35:0] sb[$];
   bit          hold_v  = 1'b0;
   logic [35:0] hold_d;

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Count accepted inputs (sampled before the edge updates state).
   always @(posedge clk) begin
      if (reset && in_valid && in_ready) n_acc++;
   end

   // Monitor: hold-stability under backpressure, then pop and compare on handshake.
   always @(negedge clk) begin
      if (reset) begin
         if (hold_v) chk("hold_stable", {3'b0, out_valid, out_status, out_data}, {4'b0001, hold_d});
         hold_v = out_valid && !out_ready;
         hold_d = {out_status, out_data};
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_output: got 0x%0h, expected no output", {out_status, out_data});
            end else begin
               chk("result", {4'b0, out_status, out_data}, {4'b0, sb.pop_front()});
            end
         end
      end else begin
         hold_v = 1'b0;
      end
   end

   // Offer one input, wait (bounded) for acceptance, record the expected result.
   task automatic send(input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] ed, input logic [3:0] es);
      int n = 0;
      in_valid  = 1'b1;
      in_data   = d;
      in_status = s;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: in_ready=0 for 50 cycles, required 1 (data 0x%0h)", d);
      end else begin
         sb.push_back({es, ed});
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((sb.size() != 0 || out_valid) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      n_tests++;
      if (sb.size() != 0 || out_valid) begin
         n_fail++;
         $display("FAIL drain_timeout: %0d results pending, required 0", sb.size());
      end
   endtask

   // Directed vectors: input data, input status, expected data, expected status.
   localparam int NV = 14;
   logic [31:0] v_in  [NV] = '{32'h3F00_0000, 32'h3F00_0003, 32'h3F00_0001, 32'h3FFF_FFFF,
                               32'h0000_0001, 32'h0000_0000, 32'hFF00_0000, 32'h7F00_0001,
                               32'h1234_5678, 32'h8000_0000, 32'h0080_0000, 32'h0000_0003,
                               32'hBF80_0000, 32'h3F00_0000};
   logic [3:0]  v_st  [NV] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                               4'b0001, 4'b0100, 4'b0001, 4'b0001,
                               4'b1000, 4'b0001, 4'b0001, 4'b0001,
                               4'b0001, 4'b0010};
   logic [31:0] v_exp [NV] = '{32'h3F80_0000, 32'h3F80_0002, 32'h3F80_0000, 32'h4000_0000,
                               32'h1480_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000,
                               32'h0000_0000, 32'h8000_0000, 32'h2000_0000, 32'h1540_0000,
                               32'hBFC0_0000, 32'h3F80_0000};
   logic [3:0]  v_xst [NV] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010,
                               4'b0001, 4'b0100, 4'b0100, 4'b0100,
                               4'b1000, 4'b0001, 4'b0001, 4'b0001,
                               4'b0001, 4'b0010};

   initial begin
      int base;
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_status = '0;
      out_ready = 1'b1;
      flags_clr = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid",  40'(out_valid),    40'h0);
      chk("rst_out_data",   40'(out_data),     40'h0);
      chk("rst_out_status", 40'(out_status),   40'h0);
      chk("rst_sticky",     40'(sticky_flags), 40'h0);
      chk("rst_in_ready",   40'(in_ready),     40'h1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Latency: captured into S1 at the accept edge, visible after the next edge
      send(32'h3F00_0000, 4'b0001, 32'h3F80_0000, 4'b0001);
      chk("lat_after_accept", 40'(out_valid), 40'h0);
      @(posedge clk);
      #1;
      chk("lat_one_edge_later", 40'(out_valid), 40'h1);
      wait_drain();

      // Directed vectors, back to back
      for (int i = 0; i < NV; i++) send(v_in[i], v_st[i], v_exp[i], v_xst[i]);
      wait_drain();

      // Backpressure: out_ready low for 4 cycles while offering 3 inputs
      out_ready = 1'b0;
      base = n_acc;
      fork
         begin
            send(32'h3F00_0003, 4'b0001, 32'h3F80_0002, 4'b0010);
            send(32'h4000_0001, 4'b0001, 32'h4000_0000, 4'b0010);
            send(32'hC000_0000, 4'b0001, 32'hC000_0000, 4'b0001);
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            chk("bp_accepts",  40'(n_acc - base), 40'd2);
            chk("bp_in_ready", 40'(in_ready),     40'h0);
            out_ready = 1'b1;
         end
      join
      wait_drain();

      // Sticky flags: clear, then one inexact result
      flags_clr = 1'b1;
      @(posedge clk);
      #1;
      flags_clr = 1'b0;
      chk("sticky_cleared", 40'(sticky_flags), 40'h0);
      send(32'h3F00_0001, 4'b0001, 32'h3F80_0000, 4'b0010);
      wait_drain();
      chk("sticky_inexact", 40'(sticky_flags), STK ? 40'h1 : 40'h0);

      // Clear in the same cycle as an overflow handshake: new bits survive
      out_ready = 1'b0;
      send(32'h0000_0000, 4'b0100, 32'h7F80_0000, 4'b0100);
      @(posedge clk);
      #1;
      chk("sticky_ovf_pending", 40'(out_valid), 40'h1);
      out_ready = 1'b1;
      flags_clr = 1'b1;
      @(posedge clk);
      #1;
      flags_clr = 1'b0;
      chk("sticky_clr_and_set", 40'(sticky_flags), STK ? 40'h2 : 40'h0);
      wait_drain();

      // Reset mid-operation discards in-flight results
      out_ready = 1'b0;
      send(32'h3F00_0000, 4'b0001, 32'h3F80_0000, 4'b0001);
      send(32'h3F00_0003, 4'b0001, 32'h3F80_0002, 4'b0010);
      reset = 1'b0;
      sb.delete();
      #2;
      chk("midrst_out_valid", 40'(out_valid),    40'h0);
      chk("midrst_in_ready",  40'(in_ready),     40'h1);
      chk("midrst_sticky",    40'(sticky_flags), 40'h0);
      @(negedge clk);
      reset     = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_idle", 40'(out_valid), 40'h0);
      send(32'h4000_0001, 4'b0001, 32'h4000_0000, 4'b0010);
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at 200000 ns, required to finish");
      $fatal(1, "watchdog expired");
   end

endmodule
